rc_rr_arbiter: RTL and testbench
================================

Name: rc_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters.
- Priority is held in a one-hot rotating ring token, reset to 3'b100 for N=3, which advances like the team's 3-bit ring counter (bit2 -> bit1 -> bit0 -> bit2).
- Sits between requesters in the user project and the shared resource.
- Adds a grant lock, a bounded hold timeout and a one-cycle dead gap between grants.

Parameters:
- N, 3, number of requesters (N >= 2).
- MAX_HOLD, 8, maximum cycles a grant may be held before forced release; 0 disables the timeout.
- CW, $clog2(MAX_HOLD+1) (minimum 1), hold counter width (derived, not to be overridden).

Ports:
- clk  input  1  single clock, rising edge.
- ori  input  1  reset, asynchronous, active-high.
- req  input  N  request lines, level, one per requester.
- done  input  N  release strobes; only the bit of the granted requester is honoured.
- gnt  output  N  one-hot grant, or all zero; registered.
- gnt_valid  output  1  OR of gnt; registered.
- token  output  N  current one-hot priority pointer; registered.
- timeout  output  1  one-cycle pulse on forced release.
- busy  output  1  high in GRANT or GAP.

Behaviour:
- Reset (ori=1, asynchronous, takes effect immediately):
  - state=IDLE, gnt=0, gnt_valid=0, timeout=0, busy=0, hold counter=0.
  - token = one-hot MSB (3'b100 for N=3).
  - Reset mid-grant drops gnt with no gap and no timeout pulse.
- Ring order: next(k) = k-1, with next(0) = N-1.
- IDLE:
  - If req != 0 at the edge, select the first set req bit searching from the token index in ring order.
  - Go to GRANT: gnt = onehot(sel), hold counter = 1.
  - Grant latency is 1 cycle from req sampled high.
  - If req == 0, stay in IDLE.
- GRANT, holding requester g:
  - Release condition at an edge: done[g]=1 OR req[g]=0.
    - Go to GAP with gnt=0, token = onehot(next(g)), timeout=0.
  - Else if MAX_HOLD != 0 and counter == MAX_HOLD:
    - Forced release: go to GAP with gnt=0, token = onehot(next(g)), timeout=1 for exactly that cycle.
  - Else stay in GRANT and increment the counter (saturating).
  - Net effect: gnt is high for at most MAX_HOLD cycles.
  - done[g] together with counter == MAX_HOLD: release wins, timeout=0.
  - done bits other than g, and req changes of other requesters, are ignored during GRANT.
- GAP:
  - Lasts one cycle; gnt=0, busy=1.
  - Timeout clears on the next edge.
  - Always goes to IDLE.
  - Minimum spacing between grants is GAP + IDLE = 2 cycles with gnt=0.
- Token:
  - Changes only on a GRANT -> GAP transition.
  - Never changes in IDLE, so a skipped requester keeps its priority position.
  - Always exactly one-hot.
- No combinational path from req or done to any output; all outputs are flops.

Test Plan:
- Reset mid-grant: assert ori while gnt=010 -> gnt=000, token=100, busy=0 in the same cycle; after release, req=111 -> gnt=100 one cycle later.
- Fairness: hold req=111 and pulse done[g] 2 cycles after each grant.
  - Grants in order 100, 010, 001, 100.
  - Each grant is separated by exactly 2 zero-gnt cycles.
  - token reads 010, 001, 100, 010 after successive releases.
- Skip: token=100, req=001 -> gnt=001; after done[0], token=100 (next(0)=2) and gnt=000.
- Timeout: req=010 held, done never asserted, MAX_HOLD=8.
  - gnt=010 for exactly 8 cycles.
  - Then gnt=000 with timeout=1 for 1 cycle.
  - token=001.
  - gnt=010 re-granted 2 cycles later.
- Simultaneous: done[g] on the 8th hold cycle -> release, timeout stays 0.
- Ignored inputs during grant to 100:
  - done=011 -> no effect.
  - Dropping req[2] releases the grant.
  - req[2] low for the first time in IDLE with req=000 -> gnt stays 000.

Source files
------------

// File: rtl/rc_rr_arbiter.sv
// rc_rr_arbiter
//
// Round-robin arbiter sharing one downstream resource among N requesters.
// Priority is a one-hot rotating token that starts at the MSB and walks
// downward (bit N-1 -> ... -> bit 0 -> bit N-1). A grant is locked until the
// owner releases it (done strobe or dropped request) or until it has been
// held for MAX_HOLD cycles, after which a one-cycle gap separates grants.
//
// Ports:
//   clk        in   1  clock, rising edge
//   ori        in   1  asynchronous active-high reset
//   req        in   N  level request lines, one per requester
//   done       in   N  release strobes; only the current owner's bit counts
//   gnt        out  N  registered one-hot grant (or zero)
//   gnt_valid  out  1  registered OR of gnt
//   token      out  N  registered one-hot priority pointer
//   timeout    out  1  one-cycle pulse when a grant is forcibly released
//   busy       out  1  high while granting or in the post-grant gap
module rc_rr_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 8,
    localparam int CW      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic         clk,
    input  logic         ori,
    input  logic [N-1:0] req,
    input  logic [N-1:0] done,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [N-1:0] token,
    output logic         timeout,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [N-1:0]  TOKEN_RST = {1'b1, {(N-1){1'b0}}};

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [N-1:0]  gnt_nxt;
    logic [N-1:0]  token_nxt;
    logic          timeout_nxt;
    logic          hold_release;
    logic          hold_expired;

    // One step along the ring: bit k moves to bit k-1, bit 0 wraps to N-1.
    function automatic logic [N-1:0] ring_next(input logic [N-1:0] v);
        return {v[0], v[N-1:1]};
    endfunction

    // First requester at or after the token position, walking in ring order.
    // The mask is rotated instead of indexed so the search is pure bit logic.
    function automatic logic [N-1:0] pick(input logic [N-1:0] r,
                                          input logic [N-1:0] t);
        logic [N-1:0] m;
        logic [N-1:0] sel;
        logic         found;
        m     = t;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && |(r & m)) begin
                sel   = r & m;
                found = 1'b1;
            end
            m = ring_next(m);
        end
        return sel;
    endfunction

    // gnt is one-hot in GRANT, so masking with it isolates the owner's bits.
    assign hold_release = (|(done & gnt)) || !(|(req & gnt));
    assign hold_expired = (MAX_HOLD != 0) && (cnt == HOLD_LIM);

    // State register; every output is a flop so nothing leaks combinationally.
    always_ff @(posedge clk or posedge ori) begin
        if (ori) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            token     <= TOKEN_RST;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= |gnt_nxt;
            token     <= token_nxt;
            timeout   <= timeout_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req) state_nxt = GRANT;
            GRANT:   if (hold_release || hold_expired) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        gnt_nxt     = gnt;
        token_nxt   = token;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt = pick(req, token);
                    cnt_nxt = CNT_ONE;
                end
            end
            GRANT: begin
                if (hold_release || hold_expired) begin
                    gnt_nxt     = '0;
                    token_nxt   = ring_next(gnt);
                    cnt_nxt     = '0;
                    // An owner release on the limit cycle is not a timeout.
                    timeout_nxt = !hold_release;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            GAP: begin
                gnt_nxt = '0;
            end
            default: begin
                gnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rc_rr_arbiter.sv
// Scoreboard bench for rc_rr_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against an integer-level model.
module tb_rc_rr_arbiter;

    localparam int N        = 3;
    localparam int MAX_HOLD = 8;

    logic         clk = 1'b0;
    logic         ori;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [N-1:0] token;
    logic         timeout;
    logic         busy;

    rc_rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .ori       (ori),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .token     (token),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         gv;
        logic [N-1:0] token;
        logic         to;
        logic         busy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: token position, owner index (-1 = none), cycles held.
    int m_tk;
    int m_owner;
    int m_held;
    bit m_gap;
    bit m_to;

    function automatic bit bit_of(input logic [N-1:0] v, input int k);
        return ((v >> k) & 1) != 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        return N'(1 << k);
    endfunction

    function void model_reset();
        m_tk    = N - 1;
        m_owner = -1;
        m_held  = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endfunction

    function void model_step(input logic [N-1:0] r, input logic [N-1:0] d);
        m_to = 1'b0;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            if (r != 0) begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_tk - i + N) % N;
                    if (m_owner < 0 && bit_of(r, k)) m_owner = k;
                end
                m_held = 1;
            end
        end else begin
            if (bit_of(d, m_owner) || !bit_of(r, m_owner)) begin
                m_tk    = (m_owner + N - 1) % N;
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
                m_tk    = (m_owner + N - 1) % N;
                m_owner = -1;
                m_gap   = 1'b1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.gnt   = (m_owner >= 0) ? onehot(m_owner) : '0;
        e.gv    = (m_owner >= 0);
        e.token = onehot(m_tk);
        e.to    = m_to;
        e.busy  = (m_owner >= 0) || m_gap;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per stimulated edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!ori && q.size() > 0) begin
            e = q.pop_front();
            check("cycle_out", {gnt, gnt_valid, token, timeout, busy}, e);
        end
    end

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        @(negedge clk);
        req  = r;
        done = d;
        model_step(r, d);
        q.push_back(model_out());
    endtask

    // Wait for the edge of the last step and let outputs settle.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        ori = 1'b1;
        #1;
        check("rst_gnt", gnt, '0);
        check("rst_state", {gnt_valid, token, timeout, busy}, {1'b0, 3'b100, 1'b0, 1'b0});
        model_reset();
        req  = '0;
        done = '0;
        @(negedge clk);
        ori = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] grants[3];
        logic [N-1:0] cur;
        logic [N-1:0] r;
        logic [N-1:0] d;

        grants = '{3'b010, 3'b001, 3'b100};
        ori  = 1'b1;
        req  = '0;
        done = '0;
        model_reset();
        #2;
        check("rst_gnt", gnt, '0);
        check("rst_state", {gnt_valid, token, timeout, busy}, {1'b0, 3'b100, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        ori = 1'b0;

        // Reset in the middle of a grant to 010.
        step(3'b010, 3'b000);
        settle();
        check("pre_rst_gnt", gnt, 3'b010);
        do_reset();
        step(3'b111, 3'b000);
        settle();
        check("post_rst_grant", gnt, 3'b100);

        // Fairness with all requesters active.
        cur = 3'b100;
        for (int i = 0; i < 3; i++) begin
            step(3'b111, 3'b000);
            step(3'b111, cur);
            settle();
            check("fair_token", token, grants[i]);
            step(3'b111, 3'b000);
            step(3'b111, 3'b000);
            settle();
            check("fair_grant", gnt, grants[i]);
            cur = grants[i];
        end
        step(3'b111, 3'b000);
        step(3'b111, 3'b100);
        settle();
        check("fair_token_last", token, 3'b010);
        step(3'b000, 3'b000);
        step(3'b000, 3'b000);
        settle();
        do_reset();

        // Skip: lone low-priority requester.
        step(3'b001, 3'b000);
        settle();
        check("skip_grant", gnt, 3'b001);
        step(3'b001, 3'b001);
        settle();
        check("skip_token", token, 3'b100);
        check("skip_gnt_off", gnt, 3'b000);
        step(3'b000, 3'b000);

        // Timeout: request held, never released.
        step(3'b010, 3'b000);
        for (int i = 0; i < MAX_HOLD; i++) step(3'b010, 3'b000);
        settle();
        check("to_pulse", timeout, 1'b1);
        check("to_token", token, 3'b001);
        check("to_gnt_off", gnt, 3'b000);
        step(3'b010, 3'b000);
        step(3'b010, 3'b000);
        settle();
        check("to_regrant", gnt, 3'b010);

        // Release on the limit cycle wins over the timeout.
        for (int i = 0; i < MAX_HOLD - 1; i++) step(3'b010, 3'b000);
        step(3'b010, 3'b010);
        settle();
        check("sim_no_timeout", timeout, 1'b0);
        check("sim_gnt_off", gnt, 3'b000);
        step(3'b000, 3'b000);

        // Foreign done bits are ignored; dropping the owner's req releases.
        step(3'b100, 3'b000);
        settle();
        check("ign_grant", gnt, 3'b100);
        step(3'b100, 3'b011);
        settle();
        check("ign_done", gnt, 3'b100);
        step(3'b000, 3'b000);
        settle();
        check("ign_drop_req", gnt, 3'b000);
        step(3'b000, 3'b000);
        step(3'b000, 3'b000);
        settle();
        check("ign_idle", gnt, 3'b000);

        // Random traffic with occasional mid-run resets.
        r = '0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) r = N'($urandom_range(0, 7));
            d = ($urandom_range(0, 4) == 0) ? N'($urandom_range(0, 7)) : '0;
            step(r, d);
            if (i % 150 == 149) begin
                settle();
                do_reset();
            end
        end
        settle();
        check("queue_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
